// File: rtl/uio_arb_pkg.sv
// Shared types and helpers for the uio pad-bank arbiter and its round-robin picker.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  always_comb begin
    o_pick = '0;
    o_idx  = '0;
    o_any  = |i_req;
    // Walk downward so the candidate closest to the pointer is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % NUM_REQ]) o_idx = ID_W'((int'(i_ptr) + k) % NUM_REQ);
    end
    if (o_any) o_pick[o_idx] = 1'b1;
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the uio pad bank with hold-time preemption and a forced
// output-enable-low turnaround between owners.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_out,
  input  logic [NUM_REQ*DATA_W-1:0]   req_oe,
  input  logic [DATA_W-1:0]           uio_in,
  output logic [NUM_REQ-1:0]          grant,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic [DATA_W-1:0]           uio_out,
  output logic [DATA_W-1:0]           uio_oe
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int HOLD_W = cnt_w(MAX_HOLD);
  localparam int TURN_W = cnt_w(TURNAROUND);

  arb_state_e          r_state, w_state_next;
  logic [NUM_REQ-1:0]  r_grant, w_grant_next;
  logic [ID_W-1:0]     r_grant_id, w_grant_id_next;
  logic [ID_W-1:0]     r_ptr, w_ptr_next;
  logic [HOLD_W-1:0]   r_hold, w_hold_next;
  logic [TURN_W-1:0]   r_turn, w_turn_next;
  logic                r_timeout, w_timeout_next;

  logic [NUM_REQ-1:0]  w_pick;
  logic [ID_W-1:0]     w_pick_idx;
  logic                w_any;
  logic                w_in_grant;
  logic [DATA_W-1:0]   w_owner_out, w_owner_oe;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .i_req  (req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx),
    .o_any  (w_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
      r_hold     <= '0;
      r_turn     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_grant_id <= w_grant_id_next;
      r_ptr      <= w_ptr_next;
      r_hold     <= w_hold_next;
      r_turn     <= w_turn_next;
      r_timeout  <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_grant_id_next = r_grant_id;
    w_ptr_next      = r_ptr;
    w_hold_next     = r_hold;
    w_turn_next     = r_turn;
    w_timeout_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next    = GRANT;
          w_grant_next    = w_pick;
          w_grant_id_next = w_pick_idx;
          w_hold_next     = '0;
        end
      end
      GRANT: begin
        w_hold_next = r_hold + 1'b1;
        // A release wins over preemption, so timeout only fires while req is still held.
        if (!req[r_grant_id] || r_hold == HOLD_W'(MAX_HOLD - 1)) begin
          w_state_next    = TURN;
          w_grant_next    = '0;
          w_grant_id_next = '0;
          w_ptr_next      = ID_W'((int'(r_grant_id) + 1) % NUM_REQ);
          w_hold_next     = '0;
          w_turn_next     = '0;
          w_timeout_next  = req[r_grant_id];
        end
      end
      TURN: begin
        if (r_turn == TURN_W'(TURNAROUND - 1)) begin
          w_state_next = IDLE;
          w_turn_next  = '0;
        end else begin
          w_turn_next = r_turn + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Pads follow the registered owner only, so req never reaches uio_out/uio_oe.
  assign w_in_grant  = (r_state == GRANT);
  assign w_owner_out = req_out[r_grant_id*DATA_W +: DATA_W];
  assign w_owner_oe  = req_oe[r_grant_id*DATA_W +: DATA_W];

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign busy     = (r_state != IDLE);
  assign timeout  = r_timeout;
  assign rd_valid = w_in_grant;
  assign rd_data  = w_in_grant ? uio_in : '0;
  assign uio_out  = w_in_grant ? w_owner_out : '0;
  assign uio_oe   = w_in_grant ? w_owner_oe : '0;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));
  a_grant_id_match: assert property (@(posedge clk) disable iff (rst)
    (r_grant == '0) || (ID_W'(onehot_to_idx(8'(r_grant))) == r_grant_id));

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed scoreboard bench for uio_bus_arbiter: expectations are queued as each step
// is driven and popped one cycle later when the arbiter's outputs are sampled.
module tb_uio_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_out;
  logic [31:0] req_oe;
  logic [7:0]  uio_in;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  uio_bus_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(16), .TURNAROUND(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_out  (req_out),
    .req_oe   (req_oe),
    .uio_in   (uio_in),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .uio_out  (uio_out),
    .uio_oe   (uio_oe)
  );

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
    logic       to;
    logic [7:0] out;
    logic [7:0] oe;
    logic [7:0] rd;
    logic       rv;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Owner data comes from the bench's own stimulus slices; idle pads must read zero.
  task automatic push(input string tag, input logic [3:0] g, input logic [1:0] id,
                      input logic b, input logic to);
    exp_t e;
    e.tag   = tag;
    e.grant = g;
    e.id    = id;
    e.busy  = b;
    e.to    = to;
    if (g != 4'b0) begin
      e.out = req_out[id*8 +: 8];
      e.oe  = req_oe[id*8 +: 8];
      e.rd  = uio_in;
      e.rv  = 1'b1;
    end else begin
      e.out = 8'h00;
      e.oe  = 8'h00;
      e.rd  = 8'h00;
      e.rv  = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s %s got=%h exp=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard empty got=0 exp=1");
      return;
    end
    e = sb.pop_front();
    chk(e.tag, "grant",    {4'b0, grant},      {4'b0, e.grant});
    chk(e.tag, "grant_id", {6'b0, grant_id},   {6'b0, e.id});
    chk(e.tag, "busy",     {7'b0, busy},       {7'b0, e.busy});
    chk(e.tag, "timeout",  {7'b0, timeout},    {7'b0, e.to});
    chk(e.tag, "uio_out",  uio_out,            e.out);
    chk(e.tag, "uio_oe",   uio_oe,             e.oe);
    chk(e.tag, "rd_data",  rd_data,            e.rd);
    chk(e.tag, "rd_valid", {7'b0, rd_valid},   {7'b0, e.rv});
    $display("step %s grant=%b id=%0d busy=%b to=%b out=%h oe=%h",
             e.tag, grant, grant_id, busy, timeout, uio_out, uio_oe);
  endtask

  task automatic step(input string tag, input logic [3:0] g, input logic [1:0] id,
                      input logic b, input logic to);
    push(tag, g, id, b, to);
    tick();
    check_pop();
  endtask

  initial begin
    rst     = 1'b1;
    req     = 4'b0000;
    req_out = 32'h0;
    req_oe  = 32'h0;
    uio_in  = 8'h00;
    tick();
    tick();
    push("reset", 4'b0, 2'd0, 1'b0, 1'b0);
    check_pop();
    rst = 1'b0;

    // Single request on requester 1, released after three GRANT cycles.
    req_out = {8'h44, 8'h33, 8'hA5, 8'h11};
    req_oe  = {8'hFF, 8'hEE, 8'h0F, 8'hCC};
    uio_in  = 8'h3C;
    req     = 4'b0010;
    step("single_g0", 4'b0010, 2'd1, 1'b1, 1'b0);
    chk("single_lit", "uio_out", uio_out, 8'hA5);
    chk("single_lit", "uio_oe",  uio_oe,  8'h0F);
    step("single_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    step("single_g2", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    step("single_turn", 4'b0, 2'd0, 1'b1, 1'b0);
    step("single_idle", 4'b0, 2'd0, 1'b0, 1'b0);

    // Requester 2 owns the pads when reset hits between edges.
    req_oe  = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    req_out = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    uio_in  = 8'h5A;
    req     = 4'b0100;
    step("mid_g0", 4'b0100, 2'd2, 1'b1, 1'b0);
    step("mid_g1", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    push("mid_rst", 4'b0, 2'd0, 1'b0, 1'b0);
    check_pop();
    req = 4'b1111;
    tick();
    rst = 1'b0;

    // All four requesting: pointer restarts at 0, each owner preempted after 16 cycles.
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 16; c++) step("rr_grant", 4'(1 << (n % 4)), 2'(n % 4), 1'b1, 1'b0);
      step("rr_turn", 4'b0, 2'd0, 1'b1, 1'b1);
      if (n == 4) req = 4'b0000;
      step("rr_idle", 4'b0, 2'd0, 1'b0, 1'b0);
    end

    // Lone persistent requester 2: 16 GRANT, TURN (timeout), IDLE, repeat.
    uio_in = 8'h96;
    req    = 4'b0100;
    for (int k = 1; k <= 40; k++) begin
      int ph;
      ph = (k - 1) % 18;
      if (ph < 16)       step("pre_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
      else if (ph == 16) step("pre_turn",  4'b0,    2'd0, 1'b1, 1'b1);
      else               step("pre_idle",  4'b0,    2'd0, 1'b0, 1'b0);
    end
    req = 4'b0000;
    step("pre_release", 4'b0, 2'd0, 1'b1, 1'b0);
    step("pre_idle_end", 4'b0, 2'd0, 1'b0, 1'b0);

    // Requester 3 owns; 0 and 1 arrive late and are served in wrap order.
    req = 4'b1000;
    step("fair_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    step("fair_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b1011;
    step("fair_g3_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0011;
    step("fair_turn3", 4'b0, 2'd0, 1'b1, 1'b0);
    step("fair_idle3", 4'b0, 2'd0, 1'b0, 1'b0);
    step("fair_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0010;
    step("fair_turn0", 4'b0, 2'd0, 1'b1, 1'b0);
    step("fair_idle0", 4'b0, 2'd0, 1'b0, 1'b0);
    step("fair_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    step("fair_turn1", 4'b0, 2'd0, 1'b1, 1'b0);
    step("fair_idle1", 4'b0, 2'd0, 1'b0, 1'b0);

    // Single-cycle pulse during TURN is ignored; the same pulse in IDLE gets one GRANT cycle.
    req = 4'b0010;
    step("gl_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    step("gl_turn", 4'b0, 2'd0, 1'b1, 1'b0);
    req = 4'b0010;
    step("gl_idle", 4'b0, 2'd0, 1'b0, 1'b0);
    req = 4'b0000;
    step("gl_still_idle", 4'b0, 2'd0, 1'b0, 1'b0);
    req = 4'b0010;
    step("ip_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    step("ip_turn", 4'b0, 2'd0, 1'b1, 1'b0);
    step("ip_idle", 4'b0, 2'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
